// File: rtl/ct_mmu_sram_acc_ctrl.sv
// Access controller in front of the 256x84 JTLB entry SRAM: zeroing sweeps
// (after reset and on invalidate-all), masked writes and single-outstanding reads.
module ct_mmu_sram_acc_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 84
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_all_req,
    output logic                  inv_all_done,
    input  logic                  wr_vld,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_rdy,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rdy,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_rdy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        INV  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic                    rd_inflight_reg;
    logic                    rsp_vld_reg;
    logic [DATA_WIDTH-1:0]   rsp_data_reg;
    logic                    done_reg;

    logic sweeping;
    logic idle_open;
    logic wr_go;
    logic rd_go;

    // Reset is qualified here too so the SRAM stays quiet while cpurst_b is low.
    assign sweeping  = cpurst_b & (state_reg != IDLE);
    assign idle_open = cpurst_b & (state_reg == IDLE) & ~inv_all_req;

    assign wr_rdy = idle_open;
    assign rd_rdy = idle_open & ~wr_vld & ~rd_inflight_reg & (~rsp_vld_reg | rsp_rdy);
    assign wr_go  = wr_vld & wr_rdy;
    assign rd_go  = rd_vld & rd_rdy;

    assign inv_all_done = done_reg;
    assign rsp_vld      = rsp_vld_reg;
    assign rsp_data     = rsp_data_reg;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (sweeping) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_reg;
        end else if (wr_go) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_mask;
            sram_a    = wr_addr;
            sram_d    = wr_data;
        end else if (rd_go) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_reg       <= INIT;
            cnt_reg         <= '0;
            rd_inflight_reg <= 1'b0;
            rsp_vld_reg     <= 1'b0;
            rsp_data_reg    <= '0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                INIT, INV: begin
                    if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (inv_all_req) begin
                        state_reg <= INV;
                    end
                end
                default: state_reg <= INIT;
            endcase

            rd_inflight_reg <= rd_go;
            // The response slot is free whenever a read is in flight, so loading wins.
            if (rd_inflight_reg) begin
                rsp_vld_reg  <= 1'b1;
                rsp_data_reg <= sram_q;
            end else if (rsp_vld_reg && rsp_rdy) begin
                rsp_vld_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ct_mmu_sram_acc_ctrl.sv
// Bench for ct_mmu_sram_acc_ctrl: behavioural SRAM, directed scenarios and random
// traffic checked every cycle against a transaction-level reference model.
module tb_ct_mmu_sram_acc_ctrl;

    localparam logic [83:0] ALL1 = {84{1'b1}};
    localparam logic [83:0] D1   = 84'h5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [83:0] M3   = 84'h0_0000_0000_03FF_FFFF_FFFF;
    localparam logic [83:0] R3   = 84'hF_FFFF_FFFF_FC00_0000_0000;
    localparam logic [83:0] D2   = 84'h1_2345_6789_ABCD_EF01_2345;

    logic        clk = 1'b0;
    logic        cpurst_b = 1'b0;
    logic        inv_all_req = 1'b0;
    logic        inv_all_done;
    logic        wr_vld = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [83:0] wr_data = '0;
    logic [83:0] wr_mask = '0;
    logic        wr_rdy;
    logic        rd_vld = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_rdy;
    logic        rsp_vld;
    logic [83:0] rsp_data;
    logic        rsp_rdy = 1'b1;
    logic [7:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [83:0] sram_wen;
    logic [83:0] sram_d;
    logic [83:0] sram_q;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ct_mmu_sram_acc_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(84)) dut (
        .forever_cpuclk(clk),
        .cpurst_b(cpurst_b),
        .inv_all_req(inv_all_req),
        .inv_all_done(inv_all_done),
        .wr_vld(wr_vld),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .wr_rdy(wr_rdy),
        .rd_vld(rd_vld),
        .rd_addr(rd_addr),
        .rd_rdy(rd_rdy),
        .rsp_vld(rsp_vld),
        .rsp_data(rsp_data),
        .rsp_rdy(rsp_rdy),
        .sram_a(sram_a),
        .sram_cen(sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),
        .sram_d(sram_d),
        .sram_q(sram_q)
    );

    function automatic logic [83:0] rnd84();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[83:0];
    endfunction

    // Behavioural SRAM, filled with garbage on the first edge so the init sweep matters.
    logic [83:0] mem [256];
    logic [83:0] q_reg;
    logic        mem_ready = 1'b0;
    assign sram_q = q_reg;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= rnd84();
            mem_ready <= 1'b1;
        end else if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            q_reg <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: expected entry contents plus the protocol state of the controller.
    logic [83:0] ref_mem [256];
    bit          m_sweep = 1'b1;
    int          m_idx = 0;
    bit          m_done = 1'b0;
    bit          m_rsp_v = 1'b0;
    logic [83:0] m_rsp_d = '0;
    bit          m_pend = 1'b0;
    logic [83:0] m_pend_d = '0;

    // One clock cycle: inputs were set at the falling edge; check, advance the model, wait.
    task automatic cycle();
        bit          exp_wr, exp_rd, wacc, racc, nd;
        logic [83:0] inv_mask;
        #1;
        if (!cpurst_b) begin
            check("rst_port", 128'({sram_cen, sram_gwen, &sram_wen, wr_rdy, rd_rdy}), 128'(5'b11100));
            m_sweep = 1'b1; m_idx = 0; m_rsp_v = 1'b0; m_pend = 1'b0; m_done = 1'b0;
        end else begin
            exp_wr = !m_sweep && !inv_all_req;
            exp_rd = exp_wr && !wr_vld && !m_pend && (!m_rsp_v || rsp_rdy);
            wacc   = exp_wr && wr_vld;
            racc   = exp_rd && rd_vld;
            check("done", 128'(inv_all_done), 128'(m_done));
            check("rsp_vld", 128'(rsp_vld), 128'(m_rsp_v));
            if (m_rsp_v) check("rsp_data", 128'(rsp_data), 128'(m_rsp_d));
            check("wr_rdy", 128'(wr_rdy), 128'(exp_wr));
            check("rd_rdy", 128'(rd_rdy), 128'(exp_rd));
            if (m_sweep) begin
                check("sweep_port", 128'({sram_cen, sram_gwen, |sram_wen, |sram_d, sram_a}),
                      128'({4'b0000, 8'(m_idx)}));
            end else if (wacc) begin
                inv_mask = ~wr_mask;
                check("wr_port", 128'({sram_cen, sram_gwen, sram_a}), 128'({2'b00, wr_addr}));
                check("wr_wen", 128'(sram_wen), 128'(inv_mask));
                check("wr_d", 128'(sram_d), 128'(wr_data));
            end else if (racc) begin
                check("rd_port", 128'({sram_cen, sram_gwen, &sram_wen, sram_a}), 128'({3'b011, rd_addr}));
            end else begin
                check("idle_port", 128'({sram_cen, sram_gwen, &sram_wen, |sram_d, sram_a}),
                      128'({4'b1110, 8'h00}));
            end

            if (m_rsp_v && rsp_rdy) m_rsp_v = 1'b0;
            if (m_pend) begin
                m_rsp_v = 1'b1; m_rsp_d = m_pend_d; m_pend = 1'b0;
            end
            nd = 1'b0;
            if (m_sweep) begin
                if (m_idx == 255) begin
                    m_sweep = 1'b0; nd = 1'b1;
                    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
                end else begin
                    m_idx++;
                end
            end else if (inv_all_req) begin
                m_sweep = 1'b1; m_idx = 0;
            end else if (wacc) begin
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
            end else if (racc) begin
                m_pend = 1'b1; m_pend_d = ref_mem[rd_addr];
            end
            m_done = nd;
        end
        @(negedge clk);
    endtask

    task automatic op(input logic wv, input logic [7:0] wa, input logic [83:0] wd, input logic [83:0] wm,
                      input logic rv, input logic [7:0] ra, input logic rr);
        wr_vld = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_vld = rv; rd_addr = ra; rsp_rdy = rr;
        cycle();
    endtask

    // Runs until the model expects the done pulse, then drops the request for that cycle.
    task automatic run_sweep();
        int guard = 0;
        while (!m_done && guard < 400) begin
            cycle();
            guard++;
        end
        inv_all_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset, then the power-on zeroing sweep.
        repeat (3) cycle();
        cpurst_b = 1'b1;
        run_sweep();
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Full-mask write then read; response two cycles after acceptance.
        op(1, 8'h12, D1, ALL1, 0, 8'h00, 1);
        op(0, 8'h00, '0, '0, 1, 8'h12, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        check("t2_vld", 128'(rsp_vld), 128'(1'b1));
        check("t2_data", 128'(rsp_data), 128'(D1));
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Partial-mask write over an all-ones entry.
        op(1, 8'h40, ALL1, ALL1, 0, 8'h00, 1);
        op(1, 8'h40, '0, M3, 0, 8'h00, 1);
        op(0, 8'h00, '0, '0, 1, 8'h40, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        check("t3_data", 128'(rsp_data), 128'(R3));
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Backpressure: response held for five cycles, next read accepted on the handshake.
        op(0, 8'h00, '0, '0, 1, 8'h12, 0);
        op(0, 8'h00, '0, '0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            op(0, 8'h00, '0, '0, 1, 8'h40, 0);
            check("t4_hold", 128'(rsp_data), 128'(D1));
        end
        op(0, 8'h00, '0, '0, 1, 8'h40, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Write beats read to the same entry; the following read sees the new data.
        op(1, 8'h07, D2, ALL1, 1, 8'h07, 1);
        op(0, 8'h00, '0, '0, 1, 8'h07, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        check("t5_data", 128'(rsp_data), 128'(D2));
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Random traffic over a small address window so entries are revisited.
        for (int n = 0; n < 600; n++) begin
            logic [83:0] m;
            case ($urandom_range(0, 2))
                0:       m = ALL1;
                1:       m = '0;
                default: m = rnd84();
            endcase
            op(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), rnd84(), m,
               ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
        end
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Invalidate-all, then every touched entry must read back as zero.
        inv_all_req = 1'b1;
        run_sweep();
        op(0, 8'h00, '0, '0, 1, 8'h12, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        check("t6_zero", 128'(rsp_data), 128'(84'h0));
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        // Held response survives a sweep start; reset at cnt=100 drops it and restarts.
        op(1, 8'h33, D1, ALL1, 0, 8'h00, 0);
        op(0, 8'h00, '0, '0, 1, 8'h33, 0);
        op(0, 8'h00, '0, '0, 0, 8'h00, 0);
        inv_all_req = 1'b1;
        for (int g = 0; g < 400 && !(m_sweep && m_idx == 100); g++) cycle();
        check("t6_held", 128'(rsp_vld), 128'(1'b1));
        inv_all_req = 1'b0;
        cpurst_b = 1'b0;
        cycle();
        cpurst_b = 1'b1;
        run_sweep();
        op(0, 8'h00, '0, '0, 1, 8'h33, 1);
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);
        check("t6_after_rst", 128'(rsp_data), 128'(84'h0));
        op(0, 8'h00, '0, '0, 0, 8'h00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
